// File: rtl/rudolv_csr_pkg.sv
// rudolv_csr_pkg: CSR addresses, modify codes and the shared UART FSM state type
package rudolv_csr_pkg;
    localparam logic [11:0] CSR_UART = 12'hbc0;
    localparam logic [11:0] CSR_LEDS = 12'hbc1;
    localparam logic [11:0] CSR_SIM  = 12'hbc2;

    localparam logic [2:0] MODIFY_NONE  = 3'd0;
    localparam logic [2:0] MODIFY_WRITE = 3'd1;
    localparam logic [2:0] MODIFY_SET   = 3'd2;
    localparam logic [2:0] MODIFY_CLEAR = 3'd3;

    typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO; the extra pointer bit tells full from empty
module sync_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam logic [DEPTH_LOG:0] ONE = 1;

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG];
    logic [DEPTH_LOG:0] wr_q, rd_q;
    logic do_push, do_pop;

    assign empty_o = wr_q == rd_q;
    assign full_o  = wr_q == {~rd_q[DEPTH_LOG], rd_q[DEPTH_LOG-1:0]};
    assign rdata_o = mem_q[rd_q[DEPTH_LOG-1:0]];
    assign do_pop  = pop_i && !empty_o;
    // a pop in the same cycle frees the slot, so a push into a full FIFO is still allowed
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= do_push ? wr_q + ONE : wr_q;
            rd_q <= do_pop ? rd_q + ONE : rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[DEPTH_LOG-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/csr_uart.sv
// csr_uart: CSR-mapped 8N1 UART; TX bytes queue in a FIFO, RX keeps one byte the core polls
module csr_uart
    import rudolv_csr_pkg::*;
#(
    parameter int          CLOCK_RATE   = 24_000_000,
    parameter int          BAUD_RATE    = 115_200,
    parameter int          TX_DEPTH_LOG = 3,
    parameter logic [11:0] CSR_ADDR     = CSR_UART
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_read,
    input  logic [2:0]  csr_modify,
    input  logic [31:0] csr_wdata,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    output logic        csr_valid,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] DEC    = CW'(1);

    logic        hit, wr, rd, push, accept, clr, tx_full, fifo_empty, tx_pop, unused_wdata;
    logic [7:0]  fifo_rdata;
    logic [31:0] status;

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s, rx_done, rx_good, rx_keep;
    logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
    logic [7:0]  rx_byte_q, rx_byte_d;

    assign hit    = csr_addr == CSR_ADDR;
    assign wr     = hit && csr_modify == MODIFY_WRITE;
    assign rd     = hit && csr_read;
    assign push   = wr && !tx_full;
    // a write into a full FIFO stalls the whole access, including a paired read
    assign accept = push || (rd && !wr);
    assign clr    = accept && rd;
    assign status = {20'b0, tx_full, ferr_q, overrun_q, rx_valid_q, rx_valid_q ? rx_byte_q : 8'h00};
    assign unused_wdata = ^csr_wdata[31:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_valid <= 1'b0;
            csr_rdata <= '0;
        end else begin
            csr_valid <= accept;
            csr_rdata <= clr ? status : '0;
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (csr_wdata[7:0]),
        .pop_i   (tx_pop),
        .rdata_o (fifo_rdata),
        .full_o  (tx_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_state_q == UART_IDLE ? tx_cnt_q : tx_cnt_q - DEC;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        case (tx_state_q)
            UART_IDLE: ;
            UART_START: if (tx_cnt_q == 0) begin
                tx_state_d = UART_DATA;
                tx_cnt_d   = RELOAD;
                tx_bit_d   = '0;
            end
            UART_DATA: if (tx_cnt_q == 0) begin
                tx_state_d = tx_bit_q == 3'd7 ? UART_STOP : UART_DATA;
                tx_cnt_d   = RELOAD;
                tx_bit_d   = tx_bit_q + 3'd1;
                tx_sh_d    = tx_sh_q >> 1;
            end
            UART_STOP: if (tx_cnt_q == 0) tx_state_d = UART_IDLE;
        endcase
        // a pop (from IDLE or the end of STOP) chains straight into START with no idle gap
        if (tx_pop) begin
            tx_state_d = UART_START;
            tx_cnt_d   = RELOAD;
            tx_sh_d    = fifo_rdata;
        end
    end

    always_comb begin
        tx_pop  = !fifo_empty && (tx_state_q == UART_IDLE || (tx_state_q == UART_STOP && tx_cnt_q == 0));
        uart_tx = tx_state_q == UART_START ? 1'b0 : tx_state_q == UART_DATA ? tx_sh_q[0] : 1'b1;
    end

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= UART_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_state_q == UART_IDLE ? rx_cnt_q : rx_cnt_q - DEC;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        case (rx_state_q)
            UART_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = UART_START;
                rx_cnt_d   = HALF;
            end
            UART_START: if (rx_cnt_q == 0) begin
                rx_state_d = rx_s ? UART_IDLE : UART_DATA;
                rx_cnt_d   = RELOAD;
                rx_bit_d   = '0;
            end
            UART_DATA: if (rx_cnt_q == 0) begin
                rx_state_d = rx_bit_q == 3'd7 ? UART_STOP : UART_DATA;
                rx_cnt_d   = RELOAD;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_sh_d    = {rx_s, rx_sh_q[7:1]};
            end
            UART_STOP: if (rx_cnt_q == 0) rx_state_d = UART_IDLE;
        endcase
    end

    // a clearing read is applied before a completing frame, so the new byte loads cleanly
    always_comb begin
        rx_done    = rx_state_q == UART_STOP && rx_cnt_q == 0;
        rx_good    = rx_done && rx_s;
        rx_keep    = rx_valid_q && !clr;
        rx_valid_d = rx_keep || rx_good;
        rx_byte_d  = rx_good && !rx_keep ? rx_sh_q : rx_byte_q;
        overrun_d  = (overrun_q && !clr) || (rx_good && rx_keep);
        ferr_d     = (ferr_q && !clr) || (rx_done && !rx_s);
    end
endmodule

// File: tb/tb_csr_uart.sv
// tb_csr_uart: scoreboard bench for csr_uart at DIV=8; TX frames and CSR reads checked against queued expectations
module tb_csr_uart;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_read = 1'b0;
    logic [2:0]  csr_modify = 3'd0;
    logic [31:0] csr_wdata = '0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_rdata;
    logic        csr_valid;
    logic        uart_rx = 1'b1;
    logic        uart_tx;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] rd_q[$];

    csr_uart #(
        .CLOCK_RATE   (800),
        .BAUD_RATE    (100),
        .TX_DEPTH_LOG (3),
        .CSR_ADDR     (12'hbc0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_read   (csr_read),
        .csr_modify (csr_modify),
        .csr_wdata  (csr_wdata),
        .csr_addr   (csr_addr),
        .csr_rdata  (csr_rdata),
        .csr_valid  (csr_valid),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic csr_op(input bit rd, input bit wr, input logic [7:0] d, output int waited);
        logic [31:0] e;
        e = rd ? rd_q.pop_front() : 32'h0;
        csr_addr   = 12'hbc0;
        csr_read   = rd;
        csr_modify = wr ? 3'd1 : 3'd0;
        csr_wdata  = {24'habcdef, d};
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!csr_valid && waited < 200);
        if (!csr_valid) check("csr_timeout", csr_valid, 1);
        else if (rd) check("rdata", csr_rdata, e);
        csr_read   = 1'b0;
        csr_modify = 3'd0;
    endtask

    task automatic csr_write(input logic [7:0] d, output int w);
        tx_q.push_back(d);
        csr_op(1'b0, 1'b1, d, w);
    endtask

    task automatic csr_read_exp(input logic [31:0] e);
        int w;
        rd_q.push_back(e);
        csr_op(1'b1, 1'b0, 8'h00, w);
        check("rd_latency", w, 1);
        @(posedge clk);
        #1;
        check("valid_pulse", csr_valid, 0);
    endtask

    task automatic decode(input int n);
        int t, prev_start;
        logic [7:0] b, e;
        prev_start = 0;
        for (int i = 0; i < n; i++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (uart_tx !== 1'b0 && t < 2000);
            if (uart_tx !== 1'b0) begin
                check("tx_start_timeout", uart_tx, 0);
                return;
            end
            if (i > 0) check("tx_gap", cyc - prev_start, 80);
            prev_start = cyc;
            repeat (4) @(negedge clk);
            check("tx_startbit", uart_tx, 0);
            for (int k = 0; k < 8; k++) begin
                repeat (8) @(negedge clk);
                b[k] = uart_tx;
            end
            repeat (8) @(negedge clk);
            check("tx_stopbit", uart_tx, 1);
            if (tx_q.size() == 0) e = 8'hxx;
            else e = tx_q.pop_front();
            check("tx_byte", b, e);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = f[k];
            repeat (8) @(posedge clk);
            #1;
        end
        uart_rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, stalls, lows;
        logic [2:0] mods [3];
        logic [11:0] addrs [3];
        mods  = '{3'd2, 3'd3, 3'd1};
        addrs = '{12'hbc0, 12'hbc0, 12'hbc1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", csr_rdata, 0);
        check("rst_valid", csr_valid, 0);
        check("rst_tx", uart_tx, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // set/clear codes and foreign addresses must not complete an access
        for (int i = 0; i < 3; i++) begin
            csr_addr   = addrs[i];
            csr_modify = mods[i];
            csr_wdata  = 32'h0000_00ee;
            @(posedge clk);
            #1;
            csr_modify = 3'd0;
            @(posedge clk);
            #1;
            check("ignored_access", csr_valid, 0);
        end

        fork
            begin
                csr_write(8'h41, w);
                check("wr_latency", w, 1);
            end
            decode(1);
        join
        repeat (10) @(posedge clk);
        #1;

        stalls = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    csr_write(8'h30 + 8'(i), w);
                    if (w > 1) stalls++;
                end
                check("stall_count", stalls, 1);
            end
            decode(10);
        join
        repeat (10) @(posedge clk);
        #1;

        send_rx(8'h5a, 1'b1);
        csr_read_exp(32'h15a);
        csr_read_exp(32'h000);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        csr_read_exp(32'h311);
        csr_read_exp(32'h000);

        send_rx(8'h33, 1'b0);
        csr_read_exp(32'h400);
        uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        csr_read_exp(32'h000);

        send_rx(8'h77, 1'b1);
        fork
            begin
                rd_q.push_back(32'h177);
                tx_q.push_back(8'h55);
                csr_op(1'b1, 1'b1, 8'h55, w);
                check("rw_latency", w, 1);
                @(posedge clk);
                #1;
                check("rw_pulse", csr_valid, 0);
            end
            decode(1);
        join
        csr_read_exp(32'h000);
        repeat (10) @(posedge clk);
        #1;

        csr_write(8'h41, w);
        csr_write(8'h42, w);
        repeat (30) @(posedge clk);
        #1;
        check("tx_mid_low", uart_tx, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", uart_tx, 1);
        check("rst_mid_valid", csr_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tx_q.delete();
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("tx_idle_after_rst", lows, 0);
        csr_read_exp(32'h000);
        fork
            csr_write(8'h5c, w);
            decode(1);
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
